// File: rtl/cordic_seq_ctrl_if.sv
// cordic_seq_ctrl_if: wrapper/counter-side handshake and datapath controls of the CORDIC sequencer
interface cordic_seq_ctrl_if #(parameter int N_W = 4);
   logic           start_i;
   logic           abort_i;
   logic [N_W-1:0] n_i;
   logic           z_i;
   logic [N_W-1:0] n_o;
   logic [1:0]     cnt_opc_o;
   logic           ld_init_o;
   logic           en_reg_o;
   logic           busy_o;
   logic           done_o;
   modport master (
      output start_i, abort_i, n_i, z_i,
      input  n_o, cnt_opc_o, ld_init_o, en_reg_o, busy_o, done_o
   );
   modport slave (
      input  start_i, abort_i, n_i, z_i,
      output n_o, cnt_opc_o, ld_init_o, en_reg_o, busy_o, done_o
   );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: sequencing FSM for the CORDIC iteration datapath
module cordic_seq_ctrl #(parameter int N_W = 4) (
   input  logic             clk_i,
   input  logic             rst_i,
   cordic_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;
   state_t         state, state_nx;
   logic [N_W-1:0] n_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) n_q <= '0;
      else if (state == IDLE && bus.start_i) n_q <= bus.n_i;
   always_comb begin
      state_nx = state == IDLE ? (bus.start_i ? LOAD : IDLE) :
                 state == LOAD ? (bus.abort_i ? IDLE : ITER) :
                 state == ITER ? (bus.abort_i ? IDLE : bus.z_i ? DONE : ITER) :
                                 IDLE;
   end
   // abort in ITER suppresses the register write and clears the counter
   always_comb begin
      bus.n_o       = n_q;
      bus.busy_o    = state == LOAD || state == ITER;
      bus.done_o    = state == DONE;
      bus.ld_init_o = state == LOAD;
      bus.en_reg_o  = state == LOAD || (state == ITER && !bus.abort_i && !bus.z_i);
      bus.cnt_opc_o = (state == ITER && !bus.abort_i) ? (bus.z_i ? 2'd1 : 2'd2) : 2'd0;
   end
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: randomized self-checking bench against a cycle-trace reference model
module tb_cordic_seq_ctrl;
   localparam int N_W = 4;
   localparam logic [5:0] IDLE_O = 6'b000000, LOAD_O = 6'b101100, INC_O = 6'b101010,
                          HOLD_O = 6'b100001, DONE_O = 6'b010000, ABRT_O = 6'b100000;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   total = 0, passed = 0;
   cordic_seq_ctrl_if #(.N_W(N_W)) bus ();
   cordic_seq_ctrl #(.N_W(N_W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));
   always #5 clk_i = ~clk_i;
   // external iteration counter as the datapath would implement it
   logic [N_W-1:0] cnt;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt <= '0;
      else if (bus.cnt_opc_o == 2'd0) cnt <= '0;
      else if (bus.cnt_opc_o == 2'd2) cnt <= cnt + 1'b1;
   assign bus.z_i = (cnt == bus.n_o);
   logic [5:0] obs;
   assign obs = {bus.busy_o, bus.done_o, bus.en_reg_o, bus.ld_init_o, bus.cnt_opc_o};
   // c counts cycles after the accepted start; ab is the cycle abort_i is raised (-1 none)
   function automatic logic [5:0] model(input int n, input int c, input int ab);
      if (ab >= 0 && c > ab) return IDLE_O;
      if (c == 0) return LOAD_O;
      if (c == ab) return ABRT_O;
      if (c <= n) return INC_O;
      if (c == n + 1) return HOLD_O;
      if (c == n + 2) return DONE_O;
      return IDLE_O;
   endfunction
   task automatic run_op(input int n, input int ab, input logic [N_W-1:0] n_late);
      int en_cnt = 0;
      bus.start_i = 1'b1;
      bus.n_i = n[N_W-1:0];
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      bus.n_i = n_late;
      for (int c = 0; c <= n + 3; c++) begin
         bus.abort_i = (c == ab);
         #1;
         total++;
         if (obs !== model(n, c, ab))
            $display("FAIL trace n=%0d ab=%0d c=%0d got=%b exp=%b", n, ab, c, obs, model(n, c, ab));
         else passed++;
         total++;
         if (bus.n_o !== n[N_W-1:0]) $display("FAIL n_o n=%0d c=%0d got=%0d", n, c, bus.n_o);
         else passed++;
         en_cnt += int'(bus.en_reg_o);
         @(posedge clk_i); #1;
      end
      bus.abort_i = 1'b0;
      total++;
      if (cnt !== '0) $display("FAIL cnt_cleared n=%0d got=%0d exp=0", n, cnt);
      else passed++;
      if (ab < 0) begin
         total++;
         if (en_cnt != n + 1) $display("FAIL en_count n=%0d got=%0d exp=%0d", n, en_cnt, n + 1);
         else passed++;
      end
   endtask
   task automatic test_reset();
      #1;
      total++;
      if (obs !== IDLE_O || bus.n_o !== '0) $display("FAIL reset got=%b n_o=%0d exp=%b n_o=0", obs, bus.n_o, IDLE_O);
      else passed++;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      total++;
      if (obs !== IDLE_O) $display("FAIL idle_after_reset got=%b exp=%b", obs, IDLE_O);
      else passed++;
   endtask
   task automatic test_basic();    run_op(4, -1, 4'd9); endtask
   task automatic test_zero();     run_op(0, -1, 4'd7); endtask
   task automatic test_max();      run_op(15, -1, 4'd1); endtask
   task automatic test_n_latch();  run_op(6, -1, 4'd2); endtask
   task automatic test_abort();
      run_op(8, 4, 4'd8);
      run_op(2, -1, 4'd11);
   endtask
   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         int n, ab;
         n = int'($urandom_range(0, 15));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + 1)) : -1;
         run_op(n, ab, N_W'($urandom));
      end
   endtask
   task automatic test_start_abort();
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      bus.n_i = 4'd1;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      #1;
      total++;
      if (obs !== LOAD_O || bus.n_o !== 4'd1) $display("FAIL start_abort got=%b n_o=%0d exp=%b n_o=1", obs, bus.n_o, LOAD_O);
      else passed++;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk_i); #1;
         total++;
         if (obs !== model(1, c, -1)) $display("FAIL start_abort_trace c=%0d got=%b exp=%b", c, obs, model(1, c, -1));
         else passed++;
      end
   endtask
   task automatic test_async_reset();
      bus.start_i = 1'b1;
      bus.n_i = 4'd8;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      repeat (6) begin @(posedge clk_i); #1; end
      total++;
      if (cnt !== 4'd5 || obs !== INC_O) $display("FAIL pre_reset cnt=%0d got=%b exp cnt=5 %b", cnt, obs, INC_O);
      else passed++;
      #2 rst_i = 1'b1;
      #1;
      total++;
      if (obs !== IDLE_O || bus.n_o !== '0 || cnt !== '0)
         $display("FAIL async_reset got=%b n_o=%0d cnt=%0d exp=%b 0 0", obs, bus.n_o, cnt, IDLE_O);
      else passed++;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      total++;
      if (obs !== IDLE_O) $display("FAIL after_async_reset got=%b exp=%b", obs, IDLE_O);
      else passed++;
   endtask
   task automatic test_back_to_back();
      int first = -1, second = -1;
      bus.start_i = 1'b1;
      bus.n_i = 4'd3;
      @(posedge clk_i); #1;
      for (int c = 0; c < 20; c++) begin
         if (bus.done_o) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(posedge clk_i); #1;
      end
      bus.start_i = 1'b0;
      total++;
      if (first != 5) $display("FAIL b2b_first_done got=%0d exp=5", first);
      else passed++;
      total++;
      if (second - first - 1 != 6) $display("FAIL b2b_gap got=%0d exp=6", second - first - 1);
      else passed++;
      repeat (12) @(posedge clk_i);
      #1;
      total++;
      if (obs !== IDLE_O) $display("FAIL b2b_drain got=%b exp=%b", obs, IDLE_O);
      else passed++;
   endtask
   initial begin
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.n_i = '0;
      test_reset();
      test_basic();
      test_zero();
      test_max();
      test_n_latch();
      test_abort();
      test_start_abort();
      test_random();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
